scan_decoder: RTL and testbench

Registered, parametrised active-low N-to-2^N decoder with a self-timed scan mode. It generalises the team's combinational enable-gated one-cold decoders: the select value can be loaded directly, or an internal counter can sweep the one-cold output across all 2^SEL_W lines at a programmable dwell rate. Its intended uses are display digit / keypad row strobing and round-robin chip-select generation. Outputs are registered, so downstream loads see glitch-free strobes.

---
 rtl/scan_decoder.sv | 100 ++++++++++
 tb/tb_scan_decoder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/scan_decoder.sv
// Registered active-low N-to-2^N decoder with direct load and self-timed scan.
// Define SCAN_DECODER_BLANK_EN to insert a one-clock all-ones gap after every scan step.
module scan_decoder #(
   parameter int SEL_W = 4,
   parameter int DWELL = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  mode,
   input  logic                  ld,
   input  logic [SEL_W-1:0]      w,
   output logic [(2**SEL_W)-1:0] y,
   output logic [SEL_W-1:0]      idx,
   output logic                  wrap
);

   localparam int OUT_W = 2**SEL_W;
   localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

`ifdef SCAN_DECODER_BLANK_EN
   typedef enum logic [1:0] {ST_OFF, ST_DIRECT, ST_SCAN, ST_BLANK} state_t;
`else
   typedef enum logic [1:0] {ST_OFF, ST_DIRECT, ST_SCAN} state_t;
`endif

   state_t             state_reg, state_next;
   logic [SEL_W-1:0]   idx_reg, idx_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic [OUT_W-1:0]   y_reg, y_next;
   logic [OUT_W-1:0]   dec_next;
   logic               wrap_reg, wrap_next;
   logic               blank_next;

   // One-cold decode of the index being written on this edge.
   generate
      for (genvar gi = 0; gi < OUT_W; gi++) begin : g_dec
         assign dec_next[gi] = (idx_next != SEL_W'(gi));
      end
   endgenerate

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      cnt_next   = cnt_reg;
      wrap_next  = 1'b0;
      blank_next = 1'b0;
      if (!en) begin
         state_next = ST_OFF;
         blank_next = 1'b1;
      end else if (!mode) begin
         state_next = ST_DIRECT;
         cnt_next   = '0;
         if (ld)
            idx_next = w;
      end else begin
         state_next = ST_SCAN;
         if (ld) begin
            idx_next = w;
            cnt_next = '0;
         end else if (state_reg == ST_SCAN) begin
            // The edge entering SCAN (from OFF, DIRECT or BLANK) only holds the counter.
            if (cnt_reg == CNT_LAST) begin
               cnt_next  = '0;
               idx_next  = idx_reg + 1'b1;
               wrap_next = (idx_reg == '1);
`ifdef SCAN_DECODER_BLANK_EN
               state_next = ST_BLANK;
               blank_next = 1'b1;
`endif
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
      end
      y_next = blank_next ? '1 : dec_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_OFF;
         idx_reg   <= '0;
         cnt_reg   <= '0;
         y_reg     <= '1;
         wrap_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         cnt_reg   <= cnt_next;
         y_reg     <= y_next;
         wrap_reg  <= wrap_next;
      end
   end

   assign y    = y_reg;
   assign idx  = idx_reg;
   assign wrap = wrap_reg;

endmodule

// File: tb/tb_scan_decoder.sv
// Directed self-checking bench for scan_decoder (SEL_W=4, DWELL=4).
// Blanking scenario is compiled in only when SCAN_DECODER_BLANK_EN is defined.
module tb_scan_decoder;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        mode;
   logic        ld;
   logic [3:0]  w;
   logic [15:0] y;
   logic [3:0]  idx;
   logic        wrap;

   int n_checks = 0;
   int n_fail   = 0;
   int n_wraps  = 0;

   scan_decoder #(.SEL_W(4), .DWELL(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .mode  (mode),
      .ld    (ld),
      .w     (w),
      .y     (y),
      .idx   (idx),
      .wrap  (wrap)
   );

   initial begin
      clk = 1'b0;
      #10;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst_n = 1'b1; en = 1'b0; mode = 1'b0; ld = 1'b0; w = 4'd0;

      // Reset with no clock edges yet
      #2 rst_n = 1'b0;
      #1;
      check("rst_y", y, 16'hFFFF);
      check("rst_idx", idx, 4'd0);
      check("rst_wrap", wrap, 1'b0);
      tick();
      rst_n = 1'b1;
      tick(2);
      check("off_y", y, 16'hFFFF);

      // Direct load
      en = 1'b1; mode = 1'b0; ld = 1'b1; w = 4'd9;
      tick();
      check("dir_load_y", y, 16'hFDFF);
      check("dir_load_idx", idx, 4'd9);
      ld = 1'b0; w = 4'd2;
      tick();
      check("dir_hold_y", y, 16'hFDFF);
      check("dir_hold_idx", idx, 4'd9);

      // Enable gating
      en = 1'b0;
      tick();
      check("en_off_y", y, 16'hFFFF);
      check("en_off_idx", idx, 4'd9);

      // Scan wrap from 15
      en = 1'b1; mode = 1'b1; ld = 1'b1; w = 4'd15;
      tick();
      check("scan_load_y", y, 16'h7FFF);
      ld = 1'b0;
      tick(3);
      check("scan_pre_idx", idx, 4'd15);
      check("scan_pre_wrap", wrap, 1'b0);
      tick();
      check("wrap_idx", idx, 4'd0);
      check("wrap_y", y, 16'hFFFE);
      check("wrap_pulse", wrap, 1'b1);

      // Full sweep: 16 steps of 4 clocks, single wrap at the end
      for (int k = 1; k <= 64; k++) begin
         logic [3:0]  e_idx;
         logic [15:0] e_y;
         tick();
         e_idx = 4'((k / 4) % 16);
         e_y   = ~(16'h0001 << e_idx);
         if (wrap) n_wraps++;
         check($sformatf("sweep_y_%0d", k), y, e_y);
      end
      check("sweep_wraps", n_wraps, 1);

      // Enable drop with counter at 2; step lands 2 clocks after y reasserts
      tick(2);
      en = 1'b0;
      tick(5);
      check("freeze_y", y, 16'hFFFF);
      check("freeze_idx", idx, 4'd0);
      en = 1'b1;
      tick();
      check("resume_y", y, 16'hFFFE);
      tick();
      check("resume_hold_idx", idx, 4'd0);
      tick();
      check("resume_step_idx", idx, 4'd1);

      // Load vs step collision at idx=7, counter=3
      ld = 1'b1; w = 4'd7;
      tick();
      ld = 1'b0;
      tick(3);
      check("coll_pre_idx", idx, 4'd7);
      ld = 1'b1; w = 4'd3;
      tick();
      check("coll_idx", idx, 4'd3);
      check("coll_y", y, 16'hFFF7);
      check("coll_wrap", wrap, 1'b0);
      ld = 1'b0;
      tick(3);
      check("coll_hold_idx", idx, 4'd3);
      tick();
      check("coll_step_idx", idx, 4'd4);

      // SCAN to DIRECT holds idx
      mode = 1'b0;
      tick(6);
      check("direct_hold_idx", idx, 4'd4);
      check("direct_hold_y", y, 16'hFFEF);

      // Async reset mid-scan, between clock edges
      mode = 1'b1;
      tick(2);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_y", y, 16'hFFFF);
      check("async_rst_idx", idx, 4'd0);
      tick();
      rst_n = 1'b1;

`ifdef SCAN_DECODER_BLANK_EN
      en = 1'b1; mode = 1'b1; ld = 1'b1; w = 4'd0;
      tick();
      ld = 1'b0;
      check("blk_y0", y, 16'hFFFE);
      tick(3);
      check("blk_y3", y, 16'hFFFE);
      tick();
      check("blk_gap_y", y, 16'hFFFF);
      check("blk_gap_idx", idx, 4'd1);
      tick();
      check("blk_next_y", y, 16'hFFFD);
      tick(4);
      check("blk_gap2_y", y, 16'hFFFF);
      #2 rst_n = 1'b0;
      #1;
      check("blk_rst_y", y, 16'hFFFF);
      check("blk_rst_idx", idx, 4'd0);
      tick();
      rst_n = 1'b1;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
